// File: rtl/tortoise_pkg.sv
// Shared frontend types: fetch entries with their exception and branch-prediction side info.
package tortoise_pkg;

    localparam int unsigned XLEN            = 32;
    localparam int unsigned INSTR_PER_FETCH = 2;
    localparam int unsigned IFQ_DEPTH       = 8;
    localparam int unsigned IFQ_CNT_W       = $clog2(IFQ_DEPTH) + 1;

    typedef struct packed {
        logic       valid;
        logic [3:0] cause;
    } exception_t;

    typedef struct packed {
        logic            is_taken;
        logic [XLEN-1:0] target;
    } sbe_predict_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        exception_t      ex;
        sbe_predict_t    predict;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_group_compact.sv
// Drops entries younger than a taken prediction or exception and packs survivors toward slot 0.
module fetch_group_compact
    import tortoise_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned KW = $clog2(N) + 1
) (
    input  logic [N-1:0][FETCH_ENTRY_W-1:0] group_i,
    output logic [N-1:0][FETCH_ENTRY_W-1:0] packed_o,
    output logic [KW-1:0]                   kept_o
);

    fetch_entry_t  entry;
    logic          stop;
    logic [KW-1:0] idx;

    always_comb begin
        packed_o = '0;
        kept_o   = '0;
        entry    = '0;
        stop     = 1'b0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            entry = fetch_entry_t'(group_i[k]);
            if (entry.valid && !stop) begin
                packed_o[idx] = group_i[k];
                idx           = idx + KW'(1);
            end
            // the redirecting entry itself survives; only younger slots are squashed
            if (entry.valid && (entry.ex.valid || entry.predict.is_taken)) begin
                stop = 1'b1;
            end
        end
        kept_o = idx;
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch queue between frontend and decode: filters/compacts fetch groups, buffers them, hands one entry per cycle.
// Optional IFQ_BYPASS_EN: zero-latency forwarding of the first kept entry when the queue is empty.
module instr_fetch_queue #(
    parameter int unsigned INSTR_PER_FETCH = tortoise_pkg::INSTR_PER_FETCH,
    parameter int unsigned DEPTH           = tortoise_pkg::IFQ_DEPTH
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_ni,
    input  logic                                                  flush_i,
    input  logic [INSTR_PER_FETCH-1:0][tortoise_pkg::FETCH_ENTRY_W-1:0] fetch_i,
    input  logic                                                  fetch_valid_i,
    output logic                                                  fetch_ready_o,
    output logic [tortoise_pkg::FETCH_ENTRY_W-1:0]                decode_o,
    output logic                                                  decode_valid_o,
    input  logic                                                  decode_ready_i,
    output logic [$clog2(DEPTH):0]                                count_o
);

    import tortoise_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned KW    = $clog2(INSTR_PER_FETCH) + 1;

    logic [FETCH_ENTRY_W-1:0]                       mem [DEPTH];
    logic [PTR_W-1:0]                               rd_ptr;
    logic [PTR_W-1:0]                               wr_ptr;
    logic [CNT_W-1:0]                               count;
    logic [INSTR_PER_FETCH-1:0][FETCH_ENTRY_W-1:0]  kept_entries;
    logic [KW-1:0]                                  kept_cnt;
    logic [KW-1:0]                                  push_cnt;
    logic                                           push;
    logic                                           pop;
    logic                                           skip;

    fetch_group_compact #(
        .N  (INSTR_PER_FETCH),
        .KW (KW)
    ) u_compact (
        .group_i  (fetch_i),
        .packed_o (kept_entries),
        .kept_o   (kept_cnt)
    );

    // credit comes from the registered count only, never from a same-cycle pop
    assign fetch_ready_o = (CNT_W'(DEPTH) - count) >= CNT_W'(INSTR_PER_FETCH);
    assign push          = fetch_valid_i && fetch_ready_o && !flush_i;
    assign count_o       = count;

`ifdef IFQ_BYPASS_EN
    logic bypass;
    assign bypass         = (count == '0) && push && (kept_cnt != '0);
    assign decode_valid_o = bypass || ((count != '0) && !flush_i);
    assign decode_o       = bypass ? kept_entries[0] : ((count != '0) ? mem[rd_ptr] : '0);
    assign skip           = bypass && decode_ready_i;
    assign pop            = decode_valid_o && decode_ready_i && !bypass;
`else
    assign decode_valid_o = (count != '0) && !flush_i;
    assign decode_o       = (count != '0) ? mem[rd_ptr] : '0;
    assign skip           = 1'b0;
    assign pop            = decode_valid_o && decode_ready_i;
`endif

    assign push_cnt = push ? (kept_cnt - KW'(skip)) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(push_cnt) - CNT_W'(pop);
        end
    end

    // storage is deliberately unreset; a forwarded entry (skip) is not written
    always_ff @(posedge clk_i) begin
        if (push) begin
            for (int i = 0; i < INSTR_PER_FETCH; i++) begin
                if (!(skip && (i == 0)) && (KW'(i) < kept_cnt)) begin
                    mem[wr_ptr + PTR_W'(i) - PTR_W'(skip)] <= kept_entries[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios then random traffic against a queue model.
module tb_instr_fetch_queue;
    import tortoise_pkg::*;

    localparam int unsigned N  = INSTR_PER_FETCH;
    localparam int unsigned D  = IFQ_DEPTH;
    localparam int unsigned EW = FETCH_ENTRY_W;
    localparam int unsigned CW = IFQ_CNT_W;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   flush_i;
    logic [N-1:0][EW-1:0]   fetch_i;
    logic                   fetch_valid_i;
    logic                   fetch_ready_o;
    logic [EW-1:0]          decode_o;
    logic                   decode_valid_o;
    logic                   decode_ready_i;
    logic [CW-1:0]          count_o;

    fetch_entry_t grp [N];
    fetch_entry_t q[$];
    fetch_entry_t ea;
    fetch_entry_t eb;
    int           checks = 0;
    int           errors = 0;
    int unsigned  seq = 0;

    instr_fetch_queue #(
        .INSTR_PER_FETCH (N),
        .DEPTH           (D)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .fetch_i        (fetch_i),
        .fetch_valid_i  (fetch_valid_i),
        .fetch_ready_o  (fetch_ready_o),
        .decode_o       (decode_o),
        .decode_valid_o (decode_valid_o),
        .decode_ready_i (decode_ready_i),
        .count_o        (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic fetch_entry_t mk(input logic v, input logic ex, input logic tk);
        fetch_entry_t e;
        e                = '0;
        e.valid          = v;
        e.pc             = 32'h1000 + seq * 4;
        e.instr          = $urandom;
        e.ex.valid       = ex;
        e.ex.cause       = ex ? 4'd2 : 4'd0;
        e.predict.is_taken = tk;
        e.predict.target = tk ? $urandom : 32'd0;
        seq++;
        return e;
    endfunction

    // One clock: drive, compare against the model at the falling edge, advance the model, pass the rising edge.
    task automatic step(input logic fv, input logic dr, input logic fl);
        fetch_entry_t  kept[$];
        logic [EW-1:0] exp_dec;
        logic          exp_v;
        logic          exp_rdy;
        logic          byp;
        for (int k = 0; k < N; k++) fetch_i[k] = grp[k];
        fetch_valid_i  = fv;
        decode_ready_i = dr;
        flush_i        = fl;
        @(negedge clk_i);
        for (int k = 0; k < N; k++) begin
            if (grp[k].valid) begin
                kept.push_back(grp[k]);
                if (grp[k].ex.valid || grp[k].predict.is_taken) break;
            end
        end
        exp_rdy = (D - q.size()) >= N;
        exp_v   = (q.size() != 0) && !fl;
        exp_dec = (q.size() != 0) ? q[0] : '0;
        byp     = 1'b0;
`ifdef IFQ_BYPASS_EN
        if (q.size() == 0 && !fl && fv && exp_rdy && kept.size() != 0) begin
            exp_v   = 1'b1;
            exp_dec = kept[0];
            byp     = 1'b1;
            if (dr) void'(kept.pop_front());
        end
`endif
        check("count", count_o, q.size());
        check("fetch_ready", fetch_ready_o, exp_rdy);
        check("decode_valid", decode_valid_o, exp_v);
        if (exp_v) check("decode_entry", decode_o, exp_dec);
        if (fl) begin
            q.delete();
        end else begin
            if (exp_v && dr && !byp) void'(q.pop_front());
            if (fv && exp_rdy) foreach (kept[i]) q.push_back(kept[i]);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic new_group();
        for (int k = 0; k < N; k++) grp[k] = mk(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst_ni         = 1'b0;
        flush_i        = 1'b0;
        fetch_valid_i  = 1'b0;
        decode_ready_i = 1'b0;
        fetch_i        = '0;
        for (int k = 0; k < N; k++) grp[k] = '0;
        @(negedge clk_i);
        check("rst_count", count_o, 0);
        check("rst_valid", decode_valid_o, 0);
        check("rst_ready", fetch_ready_o, 1);
        check("rst_decode", decode_o, 0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // two-entry group held under back-pressure
        new_group();
        ea = grp[0];
        step(1, 0, 0);
        check("hold_count", count_o, 2);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0);
            check("hold_head", decode_o, ea);
        end
        step(0, 0, 1);

        // taken prediction in slot 0 squashes slot 1
        grp[0] = mk(1, 0, 1);
        grp[1] = mk(1, 0, 0);
        step(1, 0, 0);
        check("taken_count", count_o, 1);
        step(0, 1, 0);
        step(0, 1, 0);

        // invalid slot 0, slot 1 compacted to the head
        grp[0] = mk(0, 0, 0);
        grp[1] = mk(1, 0, 0);
        eb = grp[1];
        step(1, 0, 0);
        check("hole_count", count_o, 1);
        check("hole_head", decode_o, eb);
        step(0, 1, 0);

        // fill to full and release credit one pop at a time
        for (int i = 0; i < 3; i++) begin
            new_group();
            step(1, 0, 0);
        end
        check("fill3_count", count_o, 6);
        check("fill3_ready", fetch_ready_o, 1);
        new_group();
        step(1, 0, 0);
        check("fill4_count", count_o, 8);
        check("fill4_ready", fetch_ready_o, 0);
        step(0, 1, 0);
        check("pop1_count", count_o, 7);
        check("pop1_ready", fetch_ready_o, 0);
        step(0, 1, 0);
        check("pop2_count", count_o, 6);
        check("pop2_ready", fetch_ready_o, 1);
        step(0, 0, 1);

        // streaming across pointer wrap
        for (int i = 0; i < 20; i++) begin
            new_group();
            step(1, 1, 0);
            check("stream_le_depth", count_o <= CW'(D), 1'b1);
        end
        for (int i = 0; i < 2 * D && q.size() != 0; i++) step(0, 1, 0);
        check("stream_drained", count_o, 0);

        // flush with a concurrent push and pop
        for (int i = 0; i < 3; i++) begin
            new_group();
            step(1, 0, 0);
        end
        step(0, 1, 0);
        check("preflush_count", count_o, 5);
        new_group();
        step(1, 1, 1);
        check("flush_count", count_o, 0);
        check("flush_valid", decode_valid_o, 0);
        step(0, 1, 0);

`ifdef IFQ_BYPASS_EN
        new_group();
        step(1, 1, 0);
        check("bypass_count", count_o, N - 1);
        step(0, 0, 1);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++)
                grp[k] = mk($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
